exc_sequencer: RTL and testbench
================================

# exc_sequencer

Exception/interrupt sequencer for the multi-cycle MIPS core. It watches instruction boundaries and decoder faults, arbitrates between an external interrupt and an undefined-instruction trap, and drives a fixed four-cycle sequence:
- load the error-target register with the `$k0` index;
- write the return address into the register file;
- redirect the PC to the handler vector.

While the sequence runs, it stalls the main control FSM.

## Interface
Parameters:
- `VEC_IRQ`, 32'h8000_0004, handler vector for interrupts
- `VEC_UNDEF`, 32'h8000_0008, handler vector for undefined instruction
- `K0_REG`, 5'd26, register index loaded into error target

Ports (reset reset, asynchronous, active-high; clock clk):
- `clk` in 1: clock
- `reset` in 1: asynchronous, active-high
- `irq_req` in 1: external (timer) interrupt request, level
- `pc31` in 1: PC[31] of the current instruction; 1 = kernel mode
- `decode_valid` in 1: one-cycle pulse, main FSM in decode state
- `undef_inst` in 1: decoder fault flag, qualified by `decode_valid`
- `inst_done` in 1: one-cycle pulse, last cycle of an instruction
- `abort` out 1: combinational; discard current instruction (undef trap)
- `stall_main` out 1: main FSM must hold while high
- `et_write` out 1: error-target register write enable
- `et_value` out 5: error-target data
- `epc_write` out 1: write return address to `rf[error target]`
- `pc_load` out 1: PC write enable for the vector
- `vec_pc` out 32: handler address
- `cause` out 2: 0 none, 1 irq, 2 undef; holds the last cause taken
- `irq_pend` out 1: latched pending interrupt
- `double_fault` out 1: sticky; set when an undef is seen in kernel mode
- `exc_count` out 8: exceptions taken, wraps at 255→0

## Operation
- States are IDLE, SETUP, SAVE, JUMP. Transitions are IDLE→SETUP→SAVE→JUMP→IDLE, with no other edges.

Pending interrupt latch:
- `irq_pend` sets on any cycle with `irq_req`=1.
- It clears only in the JUMP cycle of an irq-cause sequence.

Taking an undef trap:
- Condition: IDLE, `decode_valid`=1, `undef_inst`=1, `pc31`=0.
- Effects: `abort`=1 in that same cycle, `cause`←2, go to SETUP.

Taking an interrupt:
- Condition: IDLE, `inst_done`=1, (`irq_pend` or `irq_req`)=1, `pc31`=0, and no undef trap in the same cycle.
- Effects: `cause`←1, go to SETUP.
- Priority: undef beats irq. A losing irq stays pending.

Undef in kernel mode (`pc31`=1):
- No trap and no abort.
- `double_fault`←1; the instruction proceeds.

Interrupt masking:
- Interrupts are masked while `pc31`=1 or the state is not IDLE; they stay pending.

Outputs by state:
- SETUP: `et_write`=1, `et_value`=`K0_REG`.
- SAVE: `epc_write`=1.
- JUMP: `pc_load`=1, `vec_pc`=`VEC_IRQ` or `VEC_UNDEF` by `cause`; `exc_count`+1, mod 256.

Other output rules:
- `stall_main`=1 in SETUP, SAVE and JUMP.
- `et_value`=0 and `vec_pc`=0 outside their active states.
- Inputs arriving outside IDLE are ignored, except that `irq_req` still sets `irq_pend`.

## Timing
- Reset values: state IDLE; every output 0 (`abort`, `stall_main`, `et_write`, `et_value`, `epc_write`, `pc_load`, `vec_pc`, `cause`, `irq_pend`, `double_fault`, `exc_count`).
- Trigger at cycle T:
  - T: `abort` (undef only)
  - T+1: `et_write`
  - T+2: `epc_write`
  - T+3: `pc_load`
  - T+4: IDLE, `stall_main`=0; the main FSM fetches from the vector.
- `stall_main` is registered: high exactly for T+1 through T+3.
- A new trigger is accepted at T+4 at the earliest, i.e. back-to-back sequences are possible.
- Reset asserted mid-sequence: immediate return to IDLE, all outputs 0, pending and count cleared. A partially completed write is not replayed.
- `irq_req` and a trap trigger in the same cycle: the trap proceeds, and `irq_pend` is 1 at T+1.

## Test plan
- Undef at decode, `pc31`=0:
  - `abort`=1 at T.
  - `et_write`=1 with `et_value`=26 at T+1.
  - `epc_write` at T+2.
  - `pc_load` with `vec_pc`=32'h8000_0008 at T+3.
  - `cause`=2, `exc_count`=1.
- `irq_req` pulse mid-instruction, then `inst_done`:
  - `irq_pend`=1 until the JUMP cycle, `vec_pc`=32'h8000_0004, `cause`=1, `irq_pend`=0 after.
- `irq_req` high with `pc31`=1 across several `inst_done` pulses: no sequence occurs. When `pc31` drops, the next `inst_done` triggers the sequence.
- Undef with `pc31`=1: no `abort`, no stall, `double_fault`=1 and sticky.
- Pending irq plus undef at the same boundary:
  - The undef sequence runs first (`cause`=2).
  - The irq sequence starts at the next eligible `inst_done` after return.
- Reset asserted in SAVE: all outputs 0 immediately, `exc_count`=0. After 256 traps, `exc_count` wraps to 0.

Source files
------------

// File: rtl/exc_sequencer.sv
// Exception/interrupt sequencer: arbitrates undef trap vs. interrupt, runs SETUP/SAVE/JUMP.
// Latency: abort is combinational at trigger T; et_write T+1, epc_write T+2, pc_load T+3, idle T+4.
// Backpressure: holds the main FSM via registered stall_main for T+1..T+3; new triggers are taken only in IDLE.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   i_irq_req             level interrupt request, latched into o_irq_pend
//   i_pc31                kernel-mode flag of the current instruction (masks irq and undef trap)
//   i_decode_valid        pulse: main FSM in decode; qualifies i_undef_inst
//   i_undef_inst          decoder fault flag
//   i_inst_done           pulse: last cycle of an instruction (interrupt boundary)
//   o_abort               combinational; discard current instruction on undef trap
//   o_stall_main          main FSM holds while high
//   o_et_write/o_et_value error-target register write (loads K0_REG)
//   o_epc_write           write return address into rf[error target]
//   o_pc_load/o_vec_pc    PC load with handler vector
//   o_cause               last cause taken: 0 none, 1 irq, 2 undef
//   o_irq_pend            latched pending interrupt
//   o_double_fault        sticky; undef seen in kernel mode
//   o_exc_count           exceptions taken, wraps mod 256
module exc_sequencer #(
    parameter logic [31:0] VEC_IRQ   = 32'h8000_0004,
    parameter logic [31:0] VEC_UNDEF = 32'h8000_0008,
    parameter logic [4:0]  K0_REG    = 5'd26
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_irq_req,
    input  logic        i_pc31,
    input  logic        i_decode_valid,
    input  logic        i_undef_inst,
    input  logic        i_inst_done,
    output logic        o_abort,
    output logic        o_stall_main,
    output logic        o_et_write,
    output logic [4:0]  o_et_value,
    output logic        o_epc_write,
    output logic        o_pc_load,
    output logic [31:0] o_vec_pc,
    output logic [1:0]  o_cause,
    output logic        o_irq_pend,
    output logic        o_double_fault,
    output logic [7:0]  o_exc_count
);

    typedef enum logic [1:0] {IDLE, SETUP, SAVE, JUMP} state_t;

    localparam logic [1:0] CAUSE_IRQ   = 2'd1;
    localparam logic [1:0] CAUSE_UNDEF = 2'd2;

    state_t      r_state;
    logic        r_stall_main;
    logic        r_et_write;
    logic [4:0]  r_et_value;
    logic        r_epc_write;
    logic        r_pc_load;
    logic [31:0] r_vec_pc;
    logic [1:0]  r_cause;
    logic        r_irq_pend;
    logic        r_double_fault;
    logic [7:0]  r_exc_count;

    logic w_idle;
    logic w_take_undef;
    logic w_take_irq;
    logic w_kernel_undef;

    assign w_idle         = (r_state == IDLE);
    assign w_take_undef   = w_idle & i_decode_valid & i_undef_inst & ~i_pc31;
    // The raw request is OR-ed in so an irq arriving on the boundary cycle itself is taken.
    assign w_take_irq     = w_idle & i_inst_done & (r_irq_pend | i_irq_req) & ~i_pc31 & ~w_take_undef;
    assign w_kernel_undef = w_idle & i_decode_valid & i_undef_inst & i_pc31;

    // Gated with reset so abort is also 0 while reset is held.
    assign o_abort = w_take_undef & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_stall_main   <= 1'b0;
            r_et_write     <= 1'b0;
            r_et_value     <= 5'd0;
            r_epc_write    <= 1'b0;
            r_pc_load      <= 1'b0;
            r_vec_pc       <= 32'd0;
            r_cause        <= 2'd0;
            r_irq_pend     <= 1'b0;
            r_double_fault <= 1'b0;
            r_exc_count    <= 8'd0;
        end else begin
            // A new request wins over the clear at the end of an irq sequence,
            // so a still-asserted level request is not lost.
            if (i_irq_req)
                r_irq_pend <= 1'b1;
            else if (r_state == JUMP && r_cause == CAUSE_IRQ)
                r_irq_pend <= 1'b0;

            if (w_kernel_undef)
                r_double_fault <= 1'b1;

            case (r_state)
                IDLE: begin
                    if (w_take_undef || w_take_irq) begin
                        r_state      <= SETUP;
                        r_cause      <= w_take_undef ? CAUSE_UNDEF : CAUSE_IRQ;
                        r_stall_main <= 1'b1;
                        r_et_write   <= 1'b1;
                        r_et_value   <= K0_REG;
                    end
                end
                SETUP: begin
                    r_state     <= SAVE;
                    r_et_write  <= 1'b0;
                    r_et_value  <= 5'd0;
                    r_epc_write <= 1'b1;
                end
                SAVE: begin
                    r_state     <= JUMP;
                    r_epc_write <= 1'b0;
                    r_pc_load   <= 1'b1;
                    r_vec_pc    <= (r_cause == CAUSE_UNDEF) ? VEC_UNDEF : VEC_IRQ;
                    r_exc_count <= r_exc_count + 8'd1;
                end
                JUMP: begin
                    r_state      <= IDLE;
                    r_pc_load    <= 1'b0;
                    r_vec_pc     <= 32'd0;
                    r_stall_main <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_stall_main   = r_stall_main;
    assign o_et_write     = r_et_write;
    assign o_et_value     = r_et_value;
    assign o_epc_write    = r_epc_write;
    assign o_pc_load      = r_pc_load;
    assign o_vec_pc       = r_vec_pc;
    assign o_cause        = r_cause;
    assign o_irq_pend     = r_irq_pend;
    assign o_double_fault = r_double_fault;
    assign o_exc_count    = r_exc_count;

endmodule

// File: tb/tb_exc_sequencer.sv
// Bench for exc_sequencer: per-cycle vector table plus hand sequences for reset-in-SAVE and count wrap.
// Inputs are driven on the falling edge and outputs sampled 1 time unit later.
// Every expected value is written out by hand in the table or sequences below.
module tb_exc_sequencer;

    localparam logic [31:0] VI = 32'h8000_0004;
    localparam logic [31:0] VU = 32'h8000_0008;

    logic        clk;
    logic        reset;
    logic        irq_req, pc31, decode_valid, undef_inst, inst_done;
    logic        abort, stall_main, et_write, epc_write, pc_load, irq_pend, double_fault;
    logic [4:0]  et_value;
    logic [31:0] vec_pc;
    logic [1:0]  cause;
    logic [7:0]  exc_count;

    typedef struct packed {
        logic        abort;
        logic        stall;
        logic        etw;
        logic [4:0]  etv;
        logic        epcw;
        logic        pcl;
        logic [31:0] vec;
        logic [1:0]  cause;
        logic        pend;
        logic        df;
        logic [7:0]  cnt;
    } outs_t;

    // in = {reset, irq_req, pc31, decode_valid, undef_inst, inst_done}
    typedef struct {
        logic [5:0] in;
        outs_t      exp;
    } vec_t;

    int    n_checks = 0;
    int    n_errors = 0;
    outs_t act_w;
    vec_t  tbl[$];

    exc_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .i_irq_req     (irq_req),
        .i_pc31        (pc31),
        .i_decode_valid(decode_valid),
        .i_undef_inst  (undef_inst),
        .i_inst_done   (inst_done),
        .o_abort       (abort),
        .o_stall_main  (stall_main),
        .o_et_write    (et_write),
        .o_et_value    (et_value),
        .o_epc_write   (epc_write),
        .o_pc_load     (pc_load),
        .o_vec_pc      (vec_pc),
        .o_cause       (cause),
        .o_irq_pend    (irq_pend),
        .o_double_fault(double_fault),
        .o_exc_count   (exc_count)
    );

    assign act_w = {abort, stall_main, et_write, et_value, epc_write, pc_load,
                    vec_pc, cause, irq_pend, double_fault, exc_count};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // st = {abort, stall_main, et_write, epc_write, pc_load}
    function automatic vec_t mk(input logic [5:0] in, input logic [4:0] st, input logic [4:0] etv,
                                input logic [31:0] vec, input logic [1:0] c, input logic pend,
                                input logic df, input logic [7:0] cnt);
        vec_t v;
        v.in  = in;
        v.exp = '{abort: st[4], stall: st[3], etw: st[2], etv: etv, epcw: st[1], pcl: st[0],
                  vec: vec, cause: c, pend: pend, df: df, cnt: cnt};
        return v;
    endfunction

    task automatic check_outs(input string name, input outs_t exp);
        n_checks++;
        if (act_w !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act_w, exp);
        end
    endtask

    task automatic check_cnt(input string name, input logic [7:0] exp);
        n_checks++;
        if (exc_count !== exp) begin
            n_errors++;
            $display("FAIL %s: exc_count got %0d expected %0d", name, exc_count, exp);
        end
    endtask

    task automatic drive(input logic [5:0] in);
        {reset, irq_req, pc31, decode_valid, undef_inst, inst_done} = in;
    endtask

    initial begin
        outs_t exp_save;
        drive(6'b100000);

        // reset held with trap inputs active: abort must stay 0
        tbl.push_back(mk(6'b100110, 5'b00000,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(6'b000000, 5'b00000,  0, 0, 0, 0, 0, 0));
        // undef trap, user mode; decode fault during SETUP is ignored
        tbl.push_back(mk(6'b000110, 5'b10000,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(6'b000110, 5'b01100, 26, 0, 2, 0, 0, 0));
        tbl.push_back(mk(6'b000000, 5'b01010,  0, 0, 2, 0, 0, 0));
        tbl.push_back(mk(6'b000000, 5'b01001,  0, VU, 2, 0, 0, 1));
        tbl.push_back(mk(6'b000000, 5'b00000,  0, 0, 2, 0, 0, 1));
        // irq pulse mid-instruction, then inst_done
        tbl.push_back(mk(6'b010000, 5'b00000,  0, 0, 2, 0, 0, 1));
        tbl.push_back(mk(6'b000000, 5'b00000,  0, 0, 2, 1, 0, 1));
        tbl.push_back(mk(6'b000001, 5'b00000,  0, 0, 2, 1, 0, 1));
        tbl.push_back(mk(6'b000000, 5'b01100, 26, 0, 1, 1, 0, 1));
        tbl.push_back(mk(6'b000000, 5'b01010,  0, 0, 1, 1, 0, 1));
        tbl.push_back(mk(6'b000000, 5'b01001,  0, VI, 1, 1, 0, 2));
        tbl.push_back(mk(6'b000000, 5'b00000,  0, 0, 1, 0, 0, 2));
        // irq held in kernel mode across inst_done: masked, stays pending
        tbl.push_back(mk(6'b011000, 5'b00000,  0, 0, 1, 0, 0, 2));
        tbl.push_back(mk(6'b011001, 5'b00000,  0, 0, 1, 1, 0, 2));
        tbl.push_back(mk(6'b011001, 5'b00000,  0, 0, 1, 1, 0, 2));
        tbl.push_back(mk(6'b011000, 5'b00000,  0, 0, 1, 1, 0, 2));
        // pc31 drops: next inst_done takes the pending irq
        tbl.push_back(mk(6'b000001, 5'b00000,  0, 0, 1, 1, 0, 2));
        tbl.push_back(mk(6'b000000, 5'b01100, 26, 0, 1, 1, 0, 2));
        tbl.push_back(mk(6'b000000, 5'b01010,  0, 0, 1, 1, 0, 2));
        tbl.push_back(mk(6'b000000, 5'b01001,  0, VI, 1, 1, 0, 3));
        tbl.push_back(mk(6'b000000, 5'b00000,  0, 0, 1, 0, 0, 3));
        // undef in kernel mode: no abort, no stall, sticky double_fault
        tbl.push_back(mk(6'b001110, 5'b00000,  0, 0, 1, 0, 0, 3));
        tbl.push_back(mk(6'b000000, 5'b00000,  0, 0, 1, 0, 1, 3));
        tbl.push_back(mk(6'b000000, 5'b00000,  0, 0, 1, 0, 1, 3));
        // pending irq plus undef at the same boundary: undef first
        tbl.push_back(mk(6'b010000, 5'b00000,  0, 0, 1, 0, 1, 3));
        tbl.push_back(mk(6'b000111, 5'b10000,  0, 0, 1, 1, 1, 3));
        tbl.push_back(mk(6'b000000, 5'b01100, 26, 0, 2, 1, 1, 3));
        tbl.push_back(mk(6'b000000, 5'b01010,  0, 0, 2, 1, 1, 3));
        tbl.push_back(mk(6'b000000, 5'b01001,  0, VU, 2, 1, 1, 4));
        // back-to-back: irq taken on the first IDLE cycle (T+4)
        tbl.push_back(mk(6'b000001, 5'b00000,  0, 0, 2, 1, 1, 4));
        tbl.push_back(mk(6'b000000, 5'b01100, 26, 0, 1, 1, 1, 4));
        tbl.push_back(mk(6'b000000, 5'b01010,  0, 0, 1, 1, 1, 4));
        tbl.push_back(mk(6'b000000, 5'b01001,  0, VI, 1, 1, 1, 5));
        tbl.push_back(mk(6'b000000, 5'b00000,  0, 0, 1, 0, 1, 5));
        // irq_req in the trap cycle: trap proceeds, irq_pend=1 at T+1 and survives an undef JUMP
        tbl.push_back(mk(6'b010110, 5'b10000,  0, 0, 1, 0, 1, 5));
        tbl.push_back(mk(6'b000000, 5'b01100, 26, 0, 2, 1, 1, 5));
        tbl.push_back(mk(6'b000000, 5'b01010,  0, 0, 2, 1, 1, 5));
        tbl.push_back(mk(6'b000000, 5'b01001,  0, VU, 2, 1, 1, 6));
        tbl.push_back(mk(6'b000000, 5'b00000,  0, 0, 2, 1, 1, 6));

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].in);
            #1;
            check_outs($sformatf("row%0d", i), tbl[i].exp);
        end

        // Reset asserted while in SAVE
        @(negedge clk);
        drive(6'b000110);
        #1;
        check_outs("rst_seq_trigger", '{abort: 1'b1, stall: 1'b0, etw: 1'b0, etv: 5'd0, epcw: 1'b0,
                   pcl: 1'b0, vec: 32'd0, cause: 2'd2, pend: 1'b1, df: 1'b1, cnt: 8'd6});
        @(negedge clk);
        drive(6'b000000);
        @(posedge clk);
        #1;
        exp_save = '{abort: 1'b0, stall: 1'b1, etw: 1'b0, etv: 5'd0, epcw: 1'b1, pcl: 1'b0,
                     vec: 32'd0, cause: 2'd2, pend: 1'b1, df: 1'b1, cnt: 8'd6};
        check_outs("rst_seq_in_save", exp_save);
        #1;
        reset = 1'b1;
        #1;
        check_outs("rst_in_save_immediate", '0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check_outs($sformatf("rst_no_replay%0d", k), '0);
        end

        // 256 back-to-back undef traps: count reaches 255, then wraps to 0
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            if (k == 255) begin
                #1;
                check_cnt("count_255", 8'd255);
            end
            drive(6'b000110);
            @(negedge clk);
            drive(6'b000000);
            @(negedge clk);
            @(negedge clk);
        end
        @(negedge clk);
        #1;
        check_cnt("count_wrap", 8'd0);
        check_outs("after_wrap_idle", '{abort: 1'b0, stall: 1'b0, etw: 1'b0, etv: 5'd0, epcw: 1'b0,
                   pcl: 1'b0, vec: 32'd0, cause: 2'd2, pend: 1'b0, df: 1'b0, cnt: 8'd0});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
